// File: rtl/pdm_audio_sampler.sv
// rtl/pdm_audio_sampler.sv - PDM mic clock divider, boxcar ones-count decimator and 4-tap moving average
module pdm_audio_sampler #(
    parameter int MIC_CLK_DIV = 32,
    parameter int DECIM_LOG2  = 6
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic       mic_data_in,
    output logic       mic_clk_out,
    output logic [7:0] audio_out,
    output logic       audio_valid_out
);

    localparam int DIV_W = $clog2(MIC_CLK_DIV);
    localparam int SHIFT = 8 - DECIM_LOG2;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(MIC_CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(MIC_CLK_DIV / 2);
    localparam logic [DECIM_LOG2-1:0] IDX_LAST = '1;

    logic [DIV_W-1:0]      r_div_count;
    logic                  r_mic_clk;
    logic [DECIM_LOG2:0]   r_ones;
    logic [DECIM_LOG2-1:0] r_idx;
    logic [7:0]            r_h0;
    logic [7:0]            r_h1;
    logic [7:0]            r_h2;
    logic [7:0]            r_audio;
    logic                  r_valid;

    logic [DIV_W-1:0]    w_div_next;
    logic                w_strobe;
    logic [DECIM_LOG2:0] w_window;
    logic [15:0]         w_scaled;
    logic [7:0]          w_sample;
    logic [9:0]          w_sum;
    logic [7:0]          w_avg;

    assign w_div_next = (r_div_count == DIV_LAST) ? '0 : r_div_count + 1'b1;
    assign w_strobe   = enable_in && (r_div_count == DIV_LAST);
    assign w_window   = r_ones + {{DECIM_LOG2{1'b0}}, mic_data_in};
    // A full window of ones scales to 256, which saturates to 255
    assign w_scaled   = 16'(w_window) << SHIFT;
    assign w_sample   = (w_scaled > 16'd255) ? 8'hFF : w_scaled[7:0];
    assign w_sum      = {2'b00, w_sample} + {2'b00, r_h0} + {2'b00, r_h1} + {2'b00, r_h2};
    assign w_avg      = 8'(w_sum >> 2);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_count <= '0;
            r_mic_clk   <= 1'b0;
            r_ones      <= '0;
            r_idx       <= '0;
            r_h0        <= '0;
            r_h1        <= '0;
            r_h2        <= '0;
            r_audio     <= '0;
            r_valid     <= 1'b0;
        end else if (!enable_in) begin
            // History and last sample survive a stop; the partial window does not
            r_div_count <= '0;
            r_mic_clk   <= 1'b0;
            r_ones      <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_div_count <= w_div_next;
            r_mic_clk   <= (w_div_next >= DIV_HALF);
            r_valid     <= 1'b0;
            if (w_strobe) begin
                if (r_idx == IDX_LAST) begin
                    r_ones  <= '0;
                    r_idx   <= '0;
                    r_h0    <= w_sample;
                    r_h1    <= r_h0;
                    r_h2    <= r_h1;
                    r_audio <= w_avg;
                    r_valid <= 1'b1;
                end else begin
                    r_ones <= w_window;
                    r_idx  <= r_idx + 1'b1;
                end
            end
        end
    end

    assign mic_clk_out     = r_mic_clk;
    assign audio_out       = r_audio;
    assign audio_valid_out = r_valid;

endmodule
